// File: rtl/weight_byte_packer.sv
// weight_byte_packer: packs a little-endian byte stream into N-bit words and
// writes them to consecutive addresses of the single-port weight BRAM,
// starting at a latched base address, for a latched number of words.

module weight_byte_packer #(
    parameter int unsigned N        = 10,
    parameter int unsigned AddrSize = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [AddrSize-1:0] base_addr_i,
    input  logic [AddrSize-1:0] word_count_i,
    input  logic                byte_valid_i,
    input  logic [7:0]          byte_i,
    output logic                byte_ready_o,
    output logic                ram_we_o,
    output logic [AddrSize-1:0] ram_addr_o,
    output logic [N-1:0]        ram_data_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned BytesPerWord = (N + 7) / 8;
    localparam int unsigned PackW        = BytesPerWord * 8;
    localparam int unsigned ByteIdxW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;

    localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(BytesPerWord - 1);
    localparam logic [ByteIdxW-1:0] ByteOne  = ByteIdxW'(1);
    localparam logic [AddrSize-1:0] AddrOne  = AddrSize'(1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [AddrSize-1:0] base_q, base_d;
    logic [AddrSize-1:0] count_q, count_d;
    logic [AddrSize-1:0] word_idx_q, word_idx_d;
    logic [ByteIdxW-1:0] byte_idx_q, byte_idx_d;
    logic [PackW-1:0]    partial_q, partial_d;
    logic [AddrSize-1:0] addr_q, addr_d;
    logic [N-1:0]        data_q, data_d;
    logic [PackW-1:0]    assembled;

    logic ready_q, we_q, busy_q, done_q;

    // Merge the incoming byte into its slot of the partial word.
    always_comb begin
        assembled = partial_q;
        for (int unsigned k = 0; k < BytesPerWord; k++) begin
            if (byte_idx_q == ByteIdxW'(k)) begin
                assembled[8*k +: 8] = byte_i;
            end
        end
    end

    // Next-state logic: transfer sequencing, byte collection and write staging.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        partial_d  = partial_q;
        addr_d     = addr_q;
        data_d     = data_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    count_d    = word_count_i;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    partial_d  = '0;
                    state_d    = (word_count_i == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                // byte_ready_o is high in every COLLECT cycle, so valid alone accepts.
                if (byte_valid_i) begin
                    if (byte_idx_q == LastByte) begin
                        byte_idx_d = '0;
                        partial_d  = '0;
                        // Stage the write so address/data are registered during WRITE
                        // and simply hold afterwards.
                        addr_d     = base_q + word_idx_q;
                        data_d     = assembled[N-1:0];
                        state_d    = StWrite;
                    end else begin
                        byte_idx_d = byte_idx_q + ByteOne;
                        partial_d  = assembled;
                    end
                end
            end
            StWrite: begin
                if (word_idx_q == count_q - AddrOne) begin
                    state_d = StDone;
                end else begin
                    word_idx_d = word_idx_q + AddrOne;
                    state_d    = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            base_q     <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            partial_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            partial_q  <= partial_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Status outputs registered from the next state, so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (state_d == StCollect);
            we_q    <= (state_d == StWrite);
            busy_q  <= (state_d == StCollect) || (state_d == StWrite);
            done_q  <= (state_d == StDone);
        end
    end

    assign byte_ready_o = ready_q;
    assign ram_we_o     = we_q;
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
